// File: rtl/crc15_engine_pkg.sv
// Shared constants and state encoding for the CAN CRC-15 sequencer.
package crc15_engine_pkg;

    localparam int unsigned      CRC_W      = 15;
    localparam logic [CRC_W-1:0] POLY       = 15'h4599;
    localparam logic [3:0]       SHIFT_LAST = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/crc15_engine_if.sv
// Frame-controller side bus of the CRC-15 sequencer.
interface crc15_engine_if;
    import crc15_engine_pkg::*;

    logic             bit_valid;
    logic             bit_in;
    logic             start;
    logic             calc_end;
    logic             shift_req;
    logic             preload_en;
    logic [CRC_W-1:0] preload_val;
    logic [CRC_W-1:0] crc;
    logic             crc_bit_out;
    logic             crc_zero;
    logic             busy;
    logic             shift_done;

    modport master (
        output bit_valid, bit_in, start, calc_end, shift_req, preload_en, preload_val,
        input  crc, crc_bit_out, crc_zero, busy, shift_done
    );

    modport slave (
        input  bit_valid, bit_in, start, calc_end, shift_req, preload_en, preload_val,
        output crc, crc_bit_out, crc_zero, busy, shift_done
    );

endinterface

// File: rtl/crc15_engine_bit_cell.sv
// One CRC register bit: enable plus a load-select mux between preload and shift input.
module crc15_bit_cell (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  logic preload_bit,
    input  logic shift_bit,
    output logic q
);

    logic bit_d;
    logic bit_q;

    always_comb begin
        bit_d = bit_q;
        if (en) begin
            bit_d = load ? preload_bit : shift_bit;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule

// File: rtl/crc15_engine.sv
// CAN CRC-15 sequencer: accumulates over destuffed bits, shifts the CRC field out MSB-first,
// and drives the enable/load controls of the 15 register cells.
module crc15_engine
    import crc15_engine_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    crc15_engine_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic             shift_done_q;
    logic             shift_done_d;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] cell_shift;
    logic [CRC_W-1:0] cell_preload;
    logic             cell_en;
    logic             cell_load;
    logic             feedback;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_done_q <= shift_done_d;
        end
    end

    // Start clears the register through the cells' load path with a zero preload.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_done_d = 1'b0;
        cell_en      = 1'b0;
        cell_load    = 1'b0;
        cell_preload = bus.preload_val;
        feedback     = 1'b0;
        if (bus.start) begin
            state_d      = ST_CALC;
            cnt_d        = '0;
            cell_en      = 1'b1;
            cell_load    = 1'b1;
            cell_preload = '0;
        end else if (bus.preload_en) begin
            cell_en   = 1'b1;
            cell_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.shift_req) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end
                end
                ST_CALC: begin
                    if (bus.shift_req) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end else if (bus.calc_end) begin
                        state_d = ST_IDLE;
                    end else if (bus.bit_valid) begin
                        cell_en  = 1'b1;
                        feedback = bus.bit_in ^ crc_q[CRC_W-1];
                    end
                end
                ST_SHIFT: begin
                    if (bus.bit_valid) begin
                        cell_en = 1'b1;
                        if (cnt_q == SHIFT_LAST) begin
                            state_d      = ST_IDLE;
                            cnt_d        = '0;
                            shift_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        cell_shift = {crc_q[CRC_W-2:0], 1'b0} ^ (feedback ? POLY : '0);
    end

    for (genvar i = 0; i < CRC_W; i++) begin : g_cell
        crc15_bit_cell u_cell (
            .clock       (clock),
            .reset       (reset),
            .en          (cell_en),
            .load        (cell_load),
            .preload_bit (cell_preload[i]),
            .shift_bit   (cell_shift[i]),
            .q           (crc_q[i])
        );
    end

    always_comb begin
        bus.crc         = crc_q;
        bus.crc_bit_out = crc_q[CRC_W-1];
        bus.crc_zero    = (crc_q == '0);
        bus.busy        = (state_q != ST_IDLE);
        bus.shift_done  = shift_done_q;
    end

endmodule

// File: tb/tb_crc15_engine.sv
// Scoreboard bench for crc15_engine: driver pushes expected outputs, monitor pops and compares.
module tb_crc15_engine;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    crc15_engine_if bus ();

    crc15_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic [14:0] crc;
        logic        bit_out;
        logic        zero;
        logic        busy;
        logic        done;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc   = 0;
    int          tests = 0;
    int          fails = 0;
    string       cur_tag = "reset";

    // Reference model: mode 0=idle,1=calc,2=shift; sent counts bits shifted out so far.
    int unsigned m_crc  = 0;
    int unsigned m_mode = 0;
    int unsigned m_sent = 0;
    bit          m_done = 1'b0;

    task automatic model(input bit rst_n, input bit st, input bit ce, input bit sr,
                         input bit pe, input logic [14:0] pv, input bit bv, input bit bi);
        int unsigned nxt;
        m_done = 1'b0;
        if (!rst_n) begin
            m_crc = 0; m_mode = 0; m_sent = 0;
        end else if (st) begin
            m_crc = 0; m_mode = 1; m_sent = 0;
        end else if (pe) begin
            m_crc = int'(pv);
        end else if (m_mode != 2 && sr) begin
            m_mode = 2; m_sent = 0;
        end else if (m_mode == 1 && ce) begin
            m_mode = 0;
        end else if (m_mode == 1 && bv) begin
            nxt   = int'(bi) ^ ((m_crc >> 14) & 1);
            m_crc = ((m_crc * 2) ^ (nxt != 0 ? 32'h4599 : 32'h0)) % 32'h8000;
        end else if (m_mode == 2 && bv) begin
            m_crc  = (m_crc * 2) % 32'h8000;
            m_sent = m_sent + 1;
            if (m_sent == 15) begin
                m_mode = 0; m_done = 1'b1;
            end
        end
    endtask

    task automatic step(input bit rst_n, input bit st, input bit ce, input bit sr,
                        input bit pe, input logic [14:0] pv, input bit bv, input bit bi);
        exp_t e;
        @(posedge clock);
        #1;
        reset           = rst_n;
        bus.start       = st;
        bus.calc_end    = ce;
        bus.shift_req   = sr;
        bus.preload_en  = pe;
        bus.preload_val = pv;
        bus.bit_valid   = bv;
        bus.bit_in      = bi;
        model(rst_n, st, ce, sr, pe, pv, bv, bi);
        e.cyc     = cyc + 1;
        e.crc     = 15'(m_crc);
        e.bit_out = e.crc[14];
        e.zero    = (m_crc == 0);
        e.busy    = (m_mode != 0);
        e.done    = m_done;
        e.tag     = cur_tag;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 15'h0, 0, 0);
    endtask

    task automatic bitv(input bit b);
        step(1, 0, 0, 0, 0, 15'h0, 1, b);
    endtask

    task automatic send_word(input logic [14:0] w);
        for (int i = 14; i >= 0; i--) bitv(w[i]);
    endtask

    task automatic frame_10();
        step(1, 1, 0, 0, 0, 15'h0, 0, 0);
        bitv(1'b1);
        bitv(1'b0);
    endtask

    // Monitor: compares the DUT against every expectation that matures on this edge.
    initial begin
        exp_t e;
        logic [18:0] act, req;
        forever begin
            @(posedge clock);
            cyc++;
            #2;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e   = exp_q.pop_front();
                act = {bus.crc, bus.crc_bit_out, bus.crc_zero, bus.busy, bus.shift_done};
                req = {e.crc, e.bit_out, e.zero, e.busy, e.done};
                tests++;
                if (act !== req || e.cyc != cyc) begin
                    fails++;
                    $display("FAIL %s cyc=%0d: got crc=%h bit=%b zero=%b busy=%b done=%b, want crc=%h bit=%b zero=%b busy=%b done=%b",
                             e.tag, cyc, bus.crc, bus.crc_bit_out, bus.crc_zero, bus.busy, bus.shift_done,
                             e.crc, e.bit_out, e.zero, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] w;
        bus.start = 0; bus.calc_end = 0; bus.shift_req = 0; bus.preload_en = 0;
        bus.preload_val = '0; bus.bit_valid = 0; bus.bit_in = 0;

        cur_tag = "reset";
        step(0, 0, 0, 0, 0, 15'h0, 0, 0);
        step(0, 0, 0, 0, 0, 15'h0, 1, 1);
        idle();

        cur_tag = "calc_10";
        frame_10();
        cur_tag = "shift_out";
        step(1, 0, 0, 1, 0, 15'h0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            bitv(1'b0);
            if (i % 4 == 1) idle();
        end
        idle();
        idle();

        cur_tag = "rx_good";
        frame_10();
        send_word(15'h4EAB);
        step(1, 0, 1, 0, 0, 15'h0, 0, 0);
        idle();

        cur_tag = "rx_flip";
        for (int k = 0; k < 5; k++) begin
            w = 15'h4EAB;
            w[(k == 4) ? $urandom_range(14, 0) : k * 4 - (k == 3 ? 1 : 0)] ^= 1'b1;
            frame_10();
            send_word(w);
            step(1, 0, 1, 0, 0, 15'h0, 0, 0);
        end

        cur_tag = "preload";
        frame_10();
        step(1, 0, 0, 0, 1, 15'h7FFF, 1, 1);
        bitv(1'b0);
        idle();

        cur_tag = "reset_mid_shift";
        frame_10();
        step(1, 0, 0, 1, 0, 15'h0, 0, 0);
        for (int i = 0; i < 7; i++) bitv(1'b0);
        step(0, 0, 0, 0, 0, 15'h0, 1, 0);
        idle();
        idle();

        cur_tag = "start_mid_shift";
        frame_10();
        step(1, 0, 0, 1, 0, 15'h0, 0, 0);
        for (int i = 0; i < 14; i++) bitv(1'b1);
        step(1, 1, 0, 0, 0, 15'h0, 1, 0);
        idle();
        bitv(1'b1);

        cur_tag = "idle_and_collide";
        step(1, 0, 1, 0, 0, 15'h0, 0, 0);
        bitv(1'b1);
        bitv(1'b0);
        step(1, 1, 0, 0, 0, 15'h0, 0, 0);
        bitv(1'b1);
        step(1, 0, 0, 1, 0, 15'h0, 1, 1);
        step(1, 0, 0, 0, 1, 15'h1234, 1, 0);
        idle();

        cur_tag = "random";
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(199, 0) != 0,
                 $urandom_range(39, 0) == 0,
                 $urandom_range(29, 0) == 0,
                 $urandom_range(29, 0) == 0,
                 $urandom_range(59, 0) == 0,
                 15'($urandom),
                 $urandom_range(2, 0) != 0,
                 1'($urandom));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #3;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc15_engine.md
# crc15_engine

CAN CRC-15 sequencer for the bit-timing/framing path. Accumulates the CAN CRC-15 (polynomial 0x4599) over destuffed frame bits at each sample point, serially shifts the CRC field out MSB-first for transmit, and flags a zero remainder for receive checking. It sits directly above the per-bit CRC register cells and drives their enable, preload and load controls. The frame controller feeds it, and the transmit bit multiplexer consumes its serial output.

## Interface
- CRC_W, 15, CRC register width (fixed for CAN; not to be overridden)
- POLY, 15'h4599, feedback polynomial taps
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; clears register, FSM and counter
- bit_valid  in  1  one-cycle strobe per sample point; all register updates are qualified by it, except start and preload_en
- bit_in  in  1  destuffed data bit, valid with bit_valid
- start  in  1  start of frame: clear register, enter CALC
- calc_end  in  1  end of CRC coverage: leave CALC to IDLE (receive) without a bit update
- shift_req  in  1  from CALC or IDLE: enter SHIFT to send the CRC field
- preload_en  in  1  parallel load of preload_val into the register (test/CRC patch)
- preload_val  in  15  value loaded by preload_en
- crc  out  15  current register contents
- crc_bit_out  out  1  equals crc[14]; the transmit CRC bit
- crc_zero  out  1  high when crc == 0
- busy  out  1  high in CALC or SHIFT
- shift_done  out  1  one-cycle pulse after the 15th shifted bit

## Operation
- States: IDLE, CALC, SHIFT.
- Priority each cycle: reset > start > preload_en > shift_req/calc_end > bit_valid update.
- Register update in CALC on bit_valid:
  - nxt = bit_in ^ crc[14]
  - crc <= {crc[13:0],1'b0} ^ (nxt ? POLY : 0)
  - All arithmetic is modulo 15 bits.
- Register update in SHIFT on bit_valid:
  - crc <= {crc[13:0],1'b0}, with no feedback
  - shift counter (4 bits, 0..14) increments
- IDLE: register holds. bit_valid is ignored.
- Transitions:
  - IDLE –start→ CALC
  - CALC –calc_end→ IDLE
  - CALC or IDLE –shift_req→ SHIFT, counter cleared to 0
  - SHIFT –bit_valid with counter==14→ IDLE, shift_done pulses
  - start in any state → CALC, with register and counter cleared
- preload_en:
  - crc <= preload_val, in any state, with no FSM change.
  - If bit_valid arrives in the same cycle, the bit is dropped.
- shift_req or calc_end with bit_valid in the same cycle: the state change wins and the bit is not processed.
- Receive check: the controller keeps CALC through the received CRC field and then asserts calc_end. crc_zero=1 means the CRC is correct.

## Timing
- Reset values: crc=0, crc_bit_out=0, crc_zero=1, busy=0, shift_done=0, state IDLE, counter 0.
- Latency: crc and crc_bit_out reflect a bit_valid one cycle after the strobe. All outputs are registered, or decoded directly from registers.
- crc_bit_out is valid for the entire bit time following each shift. The first CRC bit is valid in the cycle after entering SHIFT.
- shift_done is asserted in the cycle after the 15th bit_valid in SHIFT. busy is low in that same cycle.
- A reset mid-SHIFT aborts with no shift_done pulse.
- A start mid-SHIFT aborts and restarts CALC with no shift_done pulse.

## Structure
- Shared package holds:
  - CRC_W
  - POLY
  - state encoding (IDLE=2'd0, CALC=2'd1, SHIFT=2'd2)
  - shift counter terminal value 4'd14
- Natural sub-module: crc15_bit_cell, a one-bit register with:
  - synchronous active-low reset
  - enable
  - load-select mux between the preload bit and the shift/feedback input
- The register is instantiated as 15 of these cells. This engine computes each cell's input, load and enable.
- The FSM and counter live in crc15_engine.

## Test plan
- Reset then start, then bits 1,0 in CALC → crc=0x4599 after the first bit, 0x4EAB after the second.
- After the two bits, shift_req plus 15 bit_valid → crc_bit_out sequence 1,0,0,1,1,1,0,1,0,1,0,1,0,1,1. shift_done pulses once, then busy=0 and crc=0.
- start, bits 1,0, then bits of 0x4EAB MSB-first in CALC, then calc_end → crc_zero=1. Flipping any one CRC bit gives crc_zero=0.
- preload_en with preload_val=0x7FFF together with bit_valid → crc=0x7FFF and the bit is ignored. The next bit 0 gives crc=0x7FFE^0x4599=0x3A67.
- reset asserted at shift 7 of SHIFT → next cycle crc=0, IDLE, busy=0, no shift_done. A start mid-SHIFT gives crc=0 and CALC.
- bit_valid in IDLE, and bit_valid in the same cycle as shift_req → crc unchanged.
